// File: rtl/rfa_wb_queue.sv
// Writeback queue between a SIMD/SIMF ALU and the register-file write arbiter.
// First-word fall-through FIFO; define RFA_WBQ_BYPASS_EN for same-cycle empty bypass.
module rfa_wb_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned WFID_WIDTH = 6,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 2048,
  parameter int unsigned MASK_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WFID_WIDTH-1:0]    in_wfid,
  input  logic [ADDR_WIDTH-1:0]    in_vgpr_addr,
  input  logic                     in_vgpr_wr_en,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic [MASK_WIDTH-1:0]    in_exec_mask,
  input  logic                     in_vcc_wr_en,
  input  logic [MASK_WIDTH-1:0]    in_vcc_value,
  output logic                     queue_entry_valid,
  input  logic                     queue_entry_serviced,
  output logic [WFID_WIDTH-1:0]    out_wfid,
  output logic [ADDR_WIDTH-1:0]    out_vgpr_addr,
  output logic                     out_vgpr_wr_en,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [MASK_WIDTH-1:0]    out_exec_mask,
  output logic                     out_vcc_wr_en,
  output logic [MASK_WIDTH-1:0]    out_vcc_value,
  output logic                     out_wr_strobe,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     err_overflow,
  output logic                     err_underflow
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned EntryW = WFID_WIDTH + ADDR_WIDTH + 1 + DATA_WIDTH + MASK_WIDTH + 1 +
                                   MASK_WIDTH;
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

  logic [EntryW-1:0] mem [DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [PtrW:0]     count_q;
  logic              err_overflow_q, err_underflow_q;

  logic [EntryW-1:0] in_entry, head;
  logic              stored_valid, full, push, push_store, pop, bypass_take;
  logic              head_vgpr_wr_en, head_vcc_wr_en;

  assign in_entry = {in_wfid, in_vgpr_addr, in_vgpr_wr_en, in_data, in_exec_mask,
                     in_vcc_wr_en, in_vcc_value};

  assign stored_valid = (count_q != '0);
  assign full         = (count_q == FullCount);
  assign in_ready     = ~full;
  assign push         = in_valid & ~full;
  assign pop          = queue_entry_serviced & stored_valid;

`ifdef RFA_WBQ_BYPASS_EN
  logic bypass;
  assign bypass      = ~stored_valid & in_valid;
  // A bypassed entry that is granted immediately never occupies storage.
  assign bypass_take = bypass & queue_entry_serviced;

  always_comb begin
    head              = mem[rd_ptr_q];
    queue_entry_valid = stored_valid;
    if (bypass) begin
      head              = in_entry;
      queue_entry_valid = 1'b1;
    end
  end
`else
  assign bypass_take       = 1'b0;
  assign head              = mem[rd_ptr_q];
  assign queue_entry_valid = stored_valid;
`endif

  assign push_store = push & ~bypass_take;

  assign {out_wfid, out_vgpr_addr, head_vgpr_wr_en, out_data, out_exec_mask,
          head_vcc_wr_en, out_vcc_value} = head;

  // Enables are qualified so an empty queue never drives stale writes.
  assign out_vgpr_wr_en = head_vgpr_wr_en & queue_entry_valid;
  assign out_vcc_wr_en  = head_vcc_wr_en & queue_entry_valid;
  assign out_wr_strobe  = queue_entry_serviced & queue_entry_valid & ~rst;

  assign occupancy     = count_q;
  assign err_overflow  = err_overflow_q;
  assign err_underflow = err_underflow_q;

  always_ff @(posedge clk) begin
    if (!rst && push_store) begin
      mem[wr_ptr_q] <= in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      if (push_store) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)        rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_store && !pop)      count_q <= count_q + 1'b1;
      else if (!push_store && pop) count_q <= count_q - 1'b1;
      if (in_valid && full)                             err_overflow_q  <= 1'b1;
      if (queue_entry_serviced && !queue_entry_valid)   err_underflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rfa_wb_queue.sv
// Randomized self-checking bench for rfa_wb_queue against a queue-based reference model.
// Honours RFA_WBQ_BYPASS_EN to match the build of the design.
module tb_rfa_wb_queue;

  localparam int unsigned DEPTH      = 4;
  localparam int unsigned WFID_WIDTH = 6;
  localparam int unsigned ADDR_WIDTH = 10;
  localparam int unsigned DATA_WIDTH = 2048;
  localparam int unsigned MASK_WIDTH = 64;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid, in_ready;
  logic [WFID_WIDTH-1:0] in_wfid;
  logic [ADDR_WIDTH-1:0] in_vgpr_addr;
  logic                  in_vgpr_wr_en;
  logic [DATA_WIDTH-1:0] in_data;
  logic [MASK_WIDTH-1:0] in_exec_mask;
  logic                  in_vcc_wr_en;
  logic [MASK_WIDTH-1:0] in_vcc_value;
  logic                  queue_entry_valid, queue_entry_serviced;
  logic [WFID_WIDTH-1:0] out_wfid;
  logic [ADDR_WIDTH-1:0] out_vgpr_addr;
  logic                  out_vgpr_wr_en;
  logic [DATA_WIDTH-1:0] out_data;
  logic [MASK_WIDTH-1:0] out_exec_mask;
  logic                  out_vcc_wr_en;
  logic [MASK_WIDTH-1:0] out_vcc_value;
  logic                  out_wr_strobe;
  logic [$clog2(DEPTH):0] occupancy;
  logic                  err_overflow, err_underflow;

  typedef struct packed {
    logic [WFID_WIDTH-1:0] wfid;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  vgpr_en;
    logic [DATA_WIDTH-1:0] data;
    logic [MASK_WIDTH-1:0] mask;
    logic                  vcc_en;
    logic [MASK_WIDTH-1:0] vcc;
  } entry_t;

  entry_t      model_q[$];
  bit          m_ovf, m_udf;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  rfa_wb_queue #(
    .DEPTH      (DEPTH),
    .WFID_WIDTH (WFID_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MASK_WIDTH (MASK_WIDTH)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_wfid              (in_wfid),
    .in_vgpr_addr         (in_vgpr_addr),
    .in_vgpr_wr_en        (in_vgpr_wr_en),
    .in_data              (in_data),
    .in_exec_mask         (in_exec_mask),
    .in_vcc_wr_en         (in_vcc_wr_en),
    .in_vcc_value         (in_vcc_value),
    .queue_entry_valid    (queue_entry_valid),
    .queue_entry_serviced (queue_entry_serviced),
    .out_wfid             (out_wfid),
    .out_vgpr_addr        (out_vgpr_addr),
    .out_vgpr_wr_en       (out_vgpr_wr_en),
    .out_data             (out_data),
    .out_exec_mask        (out_exec_mask),
    .out_vcc_wr_en        (out_vcc_wr_en),
    .out_vcc_value        (out_vcc_value),
    .out_wr_strobe        (out_wr_strobe),
    .occupancy            (occupancy),
    .err_overflow         (err_overflow),
    .err_underflow        (err_underflow)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic entry_t cur_in();
    entry_t e;
    e.wfid    = in_wfid;
    e.addr    = in_vgpr_addr;
    e.vgpr_en = in_vgpr_wr_en;
    e.data    = in_data;
    e.mask    = in_exec_mask;
    e.vcc_en  = in_vcc_wr_en;
    e.vcc     = in_vcc_value;
    return e;
  endfunction

  task automatic load_entry(input logic [ADDR_WIDTH-1:0] addr);
    in_wfid       = WFID_WIDTH'($urandom);
    in_vgpr_addr  = addr;
    in_vgpr_wr_en = 1'($urandom);
    for (int i = 0; i < DATA_WIDTH / 32; i++) in_data[i*32 +: 32] = $urandom;
    in_exec_mask  = {$urandom, $urandom};
    in_vcc_wr_en  = 1'($urandom);
    in_vcc_value  = {$urandom, $urandom};
  endtask

  // Expected combinational view of the queue given the current inputs.
  task automatic check_outputs();
    bit     byp, exp_valid;
    entry_t exp;
    byp = 1'b0;
`ifdef RFA_WBQ_BYPASS_EN
    byp = (model_q.size() == 0) && in_valid;
`endif
    exp_valid = (model_q.size() != 0) || byp;
    check_eq("valid", queue_entry_valid, exp_valid);
    check_eq("in_ready", in_ready, model_q.size() != DEPTH);
    check_eq("occupancy", occupancy, model_q.size());
    check_eq("strobe", out_wr_strobe, queue_entry_serviced && exp_valid && !rst);
    check_eq("err_overflow", err_overflow, m_ovf);
    check_eq("err_underflow", err_underflow, m_udf);
    if (exp_valid) begin
      exp = byp ? cur_in() : model_q[0];
      check_eq("wfid", out_wfid, exp.wfid);
      check_eq("addr", out_vgpr_addr, exp.addr);
      check_eq("vgpr_wr_en", out_vgpr_wr_en, exp.vgpr_en);
      check_eq("data_match", out_data === exp.data, 1);
      check_eq("exec_mask", out_exec_mask, exp.mask);
      check_eq("vcc_wr_en", out_vcc_wr_en, exp.vcc_en);
      check_eq("vcc_value", out_vcc_value, exp.vcc);
    end else begin
      check_eq("idle_vgpr_wr_en", out_vgpr_wr_en, 0);
      check_eq("idle_vcc_wr_en", out_vcc_wr_en, 0);
    end
  endtask

  task automatic model_update();
    int sz;
    bit byp_take;
    sz       = model_q.size();
    byp_take = 1'b0;
    if (rst) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
`ifdef RFA_WBQ_BYPASS_EN
      byp_take = (sz == 0) && in_valid && queue_entry_serviced;
`endif
      if (!byp_take) begin
        if (in_valid && sz == DEPTH) m_ovf = 1'b1;
        if (queue_entry_serviced && sz == 0) m_udf = 1'b1;
        if (queue_entry_serviced && sz > 0) void'(model_q.pop_front());
        if (in_valid && sz < DEPTH) model_q.push_back(cur_in());
      end
    end
  endtask

  // Inputs are already set; check, clock once, advance model.
  task automatic step();
    #1 check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_ctl(input logic v, input logic svc, input logic r);
    in_valid             = v;
    queue_entry_serviced = svc;
    rst                  = r;
  endtask

  initial begin
    bit exp_strobe;
    set_ctl(1'b0, 1'b0, 1'b1);
    load_entry('0);
    repeat (2) @(posedge clk);
    #1;
    model_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    rst   = 1'b0;
    step();

    // Single entry, held then serviced.
    load_entry(10'h010);
    in_wfid      = 6'd5;
    in_exec_mask = '1;
    set_ctl(1'b1, 1'b0, 1'b0);
    step();
    set_ctl(1'b0, 1'b0, 1'b0);
    #1;
    check_eq("tp1_wfid", out_wfid, 5);
    check_eq("tp1_occ", occupancy, 1);
    repeat (3) step();
    set_ctl(1'b0, 1'b1, 1'b0);
    step();
    set_ctl(1'b0, 1'b0, 1'b0);
    step();

    // Fill, overflow, drain in order.
    for (int i = 1; i <= 4; i++) begin
      load_entry(ADDR_WIDTH'(i));
      set_ctl(1'b1, 1'b0, 1'b0);
      step();
    end
    load_entry(10'h3ff);
    #1 check_eq("full_ready", in_ready, 0);
    step();
    set_ctl(1'b0, 1'b0, 1'b0);
    #1;
    check_eq("ovf_flag", err_overflow, 1);
    check_eq("ovf_occ", occupancy, 4);
    set_ctl(1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      #1 check_eq("drain_order", out_vgpr_addr, i);
      step();
    end

    // Steady state push+service every cycle.
    load_entry(10'h020);
    set_ctl(1'b1, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 20; i++) begin
      load_entry(ADDR_WIDTH'(10'h021 + i));
      set_ctl(1'b1, 1'b1, 1'b0);
      step();
    end
    set_ctl(1'b0, 1'b1, 1'b0);
    step();

    // Service while empty.
    set_ctl(1'b0, 1'b1, 1'b0);
    step();
    set_ctl(1'b0, 1'b0, 1'b0);
    #1;
    check_eq("udf_flag", err_underflow, 1);
    check_eq("udf_occ", occupancy, 0);
    step();

    // Reset with three queued entries and a concurrent grant.
    for (int i = 0; i < 3; i++) begin
      load_entry(ADDR_WIDTH'(10'h040 + i));
      set_ctl(1'b1, 1'b0, 1'b0);
      step();
    end
    set_ctl(1'b0, 1'b1, 1'b1);
    #1 check_eq("rst_strobe", out_wr_strobe, 0);
    step();
    set_ctl(1'b0, 1'b0, 1'b0);
    #1;
    check_eq("rst_occ", occupancy, 0);
    check_eq("rst_valid", queue_entry_valid, 0);
    check_eq("rst_ovf", err_overflow, 0);
    check_eq("rst_udf", err_underflow, 0);
    step();

    // Push and grant together from empty.
    load_entry(10'h055);
    set_ctl(1'b1, 1'b1, 1'b0);
`ifdef RFA_WBQ_BYPASS_EN
    exp_strobe = 1'b1;
`else
    exp_strobe = 1'b0;
`endif
    #1 check_eq("byp_strobe", out_wr_strobe, exp_strobe);
    step();
    set_ctl(1'b0, 1'b0, 1'b0);
    #1;
    check_eq("byp_next_valid", queue_entry_valid, !exp_strobe);
    check_eq("byp_next_occ", occupancy, exp_strobe ? 0 : 1);
    step();
    set_ctl(1'b0, 1'b1, 1'b0);
    step();

    // Randomized traffic in phases of differing pressure.
    for (int i = 0; i < 600; i++) begin
      int unsigned pv, ps;
      pv = (i < 200) ? 80 : (i < 400) ? 30 : 60;
      ps = (i < 200) ? 30 : (i < 400) ? 80 : 60;
      load_entry(ADDR_WIDTH'($urandom));
      set_ctl($urandom_range(99) < pv, $urandom_range(99) < ps, $urandom_range(149) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rfa_wb_queue.md
Name: rfa_wb_queue

Overview:
Per-functional-unit writeback queue on the requester side of the register-file write arbiter. It buffers completed SIMD/SIMF results and presents the oldest one as queue_entry_valid. When the arbiter returns queue_entry_serviced, it pops that entry and drives its fields to the VGPR/VCC write path. One instance sits between each simd/simf ALU writeback stage and the arbiter.

Parameters:
DEPTH, 4, number of entries; must be a power of 2 and at least 2.
WFID_WIDTH, 6, wavefront id width.
ADDR_WIDTH, 10, VGPR destination address width.
DATA_WIDTH, 2048, write data width (64 lanes x 32 bits).
MASK_WIDTH, 64, exec/VCC mask width.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  ALU presents a writeback entry this cycle.
in_ready  output  1  queue can accept an entry; equals ~full.
in_wfid  input  WFID_WIDTH  wavefront id.
in_vgpr_addr  input  ADDR_WIDTH  destination VGPR.
in_vgpr_wr_en  input  1  entry writes a VGPR.
in_data  input  DATA_WIDTH  lane data.
in_exec_mask  input  MASK_WIDTH  lane write mask.
in_vcc_wr_en  input  1  entry writes VCC.
in_vcc_value  input  MASK_WIDTH  VCC value.
queue_entry_valid  output  1  head entry present (request to arbiter).
queue_entry_serviced  input  1  arbiter grant; head is written this cycle.
out_wfid, out_vgpr_addr, out_vgpr_wr_en, out_data, out_exec_mask, out_vcc_wr_en, out_vcc_value  output  same widths as in_*  head entry fields.
out_wr_strobe  output  1  equals queue_entry_serviced & queue_entry_valid; qualifies out_* as a real write.
occupancy  output  log2(DEPTH)+1  current entry count.
err_overflow  output  1  sticky; push attempted while full.
err_underflow  output  1  sticky; serviced while empty.

Behaviour:
- Reset (synchronous, active-high): rd_ptr=0, wr_ptr=0, count=0, err_overflow=0, err_underflow=0. queue_entry_valid=0, in_ready=1, out_wr_strobe=0. Storage array is not reset.
- out_* with out_vgpr_wr_en and out_vcc_wr_en forced to 0 when empty, so no stale enables are driven.
- First-word fall-through. The head is visible on out_* combinationally from storage[rd_ptr].
- queue_entry_valid = (count != 0). Valid is held, with head stable, until serviced.
- push = in_valid & ~full. A push writes storage[wr_ptr] and increments wr_ptr modulo DEPTH.
- An entry pushed in cycle N is visible as head in cycle N+1 at the earliest; there is 1 cycle latency from in to out.
- pop = queue_entry_serviced & queue_entry_valid. A pop increments rd_ptr modulo DEPTH.
- count: +1 on push only, -1 on pop only, unchanged on push and pop together.
- full = (count == DEPTH). in_ready has no combinational dependence on queue_entry_serviced: a push is refused when full, even if a pop happens in the same cycle.
- in_valid while full: entry dropped, err_overflow set to 1 and held until rst.
- queue_entry_serviced while empty: no state change, err_underflow set to 1.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally; count disambiguates full from empty.
- Reset mid-operation: all pending entries are discarded and none are written out. rst has priority over push and pop in the same cycle.
- No state machine beyond the FIFO control. Per-cycle precedence: rst > (push, pop).

Optional Feature:
Macro RFA_WBQ_BYPASS_EN.
- Defined: when count==0 and in_valid, the in_* fields drive out_* combinationally and queue_entry_valid=1 in the same cycle.
  - If queue_entry_serviced is also asserted that cycle, the entry is consumed without being stored: count stays 0 and out_wr_strobe=1.
  - If not serviced, the entry is pushed normally.
  - The path from in_valid to queue_entry_valid becomes combinational.
- Undefined: strict 1-cycle registered latency as described above, with no combinational path from in_* to out_*.

Test Plan:
- Reset, then push 1 entry (wfid=5, addr=0x010, mask=all-ones) with serviced=0 -> the next cycle queue_entry_valid=1, out_wfid=5, occupancy=1. Hold 3 cycles with head stable, then assert serviced 1 cycle -> out_wr_strobe=1, then valid=0 and occupancy=0.
- Push 4 entries, addr=1..4, back-to-back -> occupancy=4, in_ready=0. A 5th push sets err_overflow=1 and occupancy stays 4. Service 4 times -> addresses come out in order 1,2,3,4.
- Steady state with push and service every cycle for 20 cycles, addr incrementing -> occupancy constant at 1 and no entry lost or reordered; pointers wrap through 0 at least 4 times.
- Assert serviced while empty -> err_underflow=1, pointers and occupancy unchanged, out_wr_strobe=0.
- With 3 entries queued, assert rst for 1 cycle together with serviced=1 -> the next cycle occupancy=0, queue_entry_valid=0, both error flags 0, no out_wr_strobe.
- Bypass on vs off, from empty, in_valid and serviced in the same cycle:
  - RFA_WBQ_BYPASS_EN defined -> out_wr_strobe=1 that cycle and occupancy stays 0.
  - Undefined -> out_wr_strobe=0, and valid rises the next cycle.
